// File: rtl/stats_scheduler_if.sv
// Bundle of the window input, result output and the two statistics-unit ports
// around stats_scheduler. The scheduler uses the slave view; its environment uses the master view.
interface stats_scheduler_if #(
    parameter int SIZE = 512
);
    logic [SIZE-1:0] in_values;
    logic            in_valid;
    logic            in_ready;

    logic [7:0]      out_mean;
    logic [7:0]      out_var;
    logic            out_error;
    logic            out_valid;
    logic            out_ready;

    logic            mean_rst;
    logic [SIZE-1:0] mean_values;
    logic            mean_in_valid;
    logic [7:0]      mean_value;
    logic            mean_out_valid;

    logic            var_rst;
    logic [SIZE-1:0] var_values;
    logic [7:0]      var_mean;
    logic            var_in_valid;
    logic [7:0]      var_value;
    logic            var_out_valid;

    modport slave (
        input  in_values, in_valid, out_ready,
               mean_value, mean_out_valid,
               var_value, var_out_valid,
        output in_ready,
               out_mean, out_var, out_error, out_valid,
               mean_rst, mean_values, mean_in_valid,
               var_rst, var_values, var_mean, var_in_valid
    );

    modport master (
        output in_values, in_valid, out_ready,
               mean_value, mean_out_valid,
               var_value, var_out_valid,
        input  in_ready,
               out_mean, out_var, out_error, out_valid,
               mean_rst, mean_values, mean_in_valid,
               var_rst, var_values, var_mean, var_in_valid
    );
endinterface

// File: rtl/stats_scheduler.sv
// Sequences one pixel window through an external mean unit and then a variance unit,
// with a per-unit response timeout, and presents the pair of results on a valid/ready port.
module stats_scheduler #(
    parameter int SIZE    = 512,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    stats_scheduler_if.slave       bus,
    output logic                   busy,
    output logic [15:0]            job_count
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MEAN_START,
        MEAN_WAIT,
        VAR_START,
        VAR_WAIT,
        OUTPUT
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [SIZE-1:0] window_buf;
    logic [7:0]      mean_reg;
    logic [7:0]      var_reg;
    logic            err_reg;
    logic [CNT_W-1:0] wait_cnt;

    logic            accept;
    logic            mean_hit;
    logic            var_hit;
    logic            mean_timeout;
    logic            var_timeout;
    logic            handshake;

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        mean_hit     = 1'b0;
        var_hit      = 1'b0;
        mean_timeout = 1'b0;
        var_timeout  = 1'b0;
        handshake    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR:      state_next = MEAN_START;
            MEAN_START: state_next = MEAN_WAIT;
            MEAN_WAIT: begin
                // A response arriving on the timeout cycle still counts as success.
                if (bus.mean_out_valid) begin
                    mean_hit   = 1'b1;
                    state_next = VAR_START;
                end else if (wait_cnt == TIMEOUT_C) begin
                    mean_timeout = 1'b1;
                    state_next   = OUTPUT;
                end
            end
            VAR_START:  state_next = VAR_WAIT;
            VAR_WAIT: begin
                if (bus.var_out_valid) begin
                    var_hit    = 1'b1;
                    state_next = OUTPUT;
                end else if (wait_cnt == TIMEOUT_C) begin
                    var_timeout = 1'b1;
                    state_next  = OUTPUT;
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default:    state_next = IDLE;
        endcase
    end

    // Unit resets follow the block reset combinationally so an abandoned job
    // also clears whatever the units were working on.
    always_comb begin
        bus.in_ready      = (state == IDLE);
        bus.out_valid     = (state == OUTPUT);
        bus.mean_in_valid = (state == MEAN_START);
        bus.var_in_valid  = (state == VAR_START);
        bus.mean_rst      = !rst || (state == CLEAR);
        bus.var_rst       = !rst || (state == CLEAR);
        busy              = (state != IDLE);
    end

    assign bus.mean_values = window_buf;
    assign bus.var_values  = window_buf;
    assign bus.var_mean    = mean_reg;
    assign bus.out_mean    = mean_reg;
    assign bus.out_var     = var_reg;
    assign bus.out_error   = err_reg;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the window buffer is an ordinary register, not a memory array, so it
    // is cleared by reset like the rest of the datapath.
    always_ff @(posedge clk) begin
        if (!rst) begin
            window_buf <= '0;
            mean_reg   <= '0;
            var_reg    <= '0;
            err_reg    <= 1'b0;
            wait_cnt   <= '0;
            job_count  <= '0;
        end else begin
            if (accept) begin
                window_buf <= bus.in_values;
            end

            if (mean_hit) begin
                mean_reg <= bus.mean_value;
            end

            if (var_hit) begin
                var_reg <= bus.var_value;
                err_reg <= 1'b0;
            end

            // A mean timeout leaves neither result valid; a variance timeout keeps the mean.
            if (mean_timeout) begin
                mean_reg <= '0;
                var_reg  <= '0;
                err_reg  <= 1'b1;
            end

            if (var_timeout) begin
                var_reg <= '0;
                err_reg <= 1'b1;
            end

            // The counter reads 0 during a START cycle and then counts cycles since it.
            if (state_next == MEAN_START || state_next == VAR_START) begin
                wait_cnt <= '0;
            end else if ((state == MEAN_START || state == MEAN_WAIT ||
                          state == VAR_START  || state == VAR_WAIT) &&
                         wait_cnt != TIMEOUT_C) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            if (handshake) begin
                job_count <= job_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_stats_scheduler.sv
// Scoreboard bench for stats_scheduler: behavioural mean/variance units answer each start
// pulse after a set delay; expected results are queued at window accept and compared at handshake.
module tb_stats_scheduler;

    localparam int SIZE = 64;
    localparam int NPIX = SIZE / 8;

    typedef struct packed {
        logic [7:0] mean;
        logic [7:0] vr;
        logic       err;
    } result_t;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic        busy_a;
    logic        busy_b;
    logic [15:0] jc_a;
    logic [15:0] jc_b;

    int chk_cnt = 0;
    int err_cnt = 0;

    result_t qa[$];
    result_t qb[$];

    // Unit model controls
    int a_m_dly = 70;
    int a_v_dly = 70;
    int b_m_dly = 3;
    int b_v_dly = 4;
    bit b_m_en  = 1'b1;
    bit b_v_en  = 1'b1;

    int am_cnt, av_cnt, bm_cnt, bv_cnt;
    bit am_busy, av_busy, bm_busy, bv_busy;
    bit clr_b = 1'b0;
    int vpulse_b = 0;

    always #5 clk = ~clk;

    stats_scheduler_if #(.SIZE(SIZE)) ifa ();
    stats_scheduler_if #(.SIZE(SIZE)) ifb ();

    stats_scheduler #(.SIZE(SIZE), .TIMEOUT(1023)) dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .bus       (ifa),
        .busy      (busy_a),
        .job_count (jc_a)
    );

    stats_scheduler #(.SIZE(SIZE), .TIMEOUT(15)) dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .bus       (ifb),
        .busy      (busy_b),
        .job_count (jc_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mean_of(input logic [SIZE-1:0] w);
        int s;
        s = 0;
        for (int i = 0; i < NPIX; i++) s += int'(w[i*8 +: 8]);
        return 8'(s / NPIX);
    endfunction

    function automatic logic [7:0] var_of(input logic [SIZE-1:0] w, input logic [7:0] m);
        int s;
        int d;
        s = 0;
        for (int i = 0; i < NPIX; i++) begin
            d = int'(w[i*8 +: 8]) - int'(m);
            s += d * d;
        end
        return 8'(s / NPIX);
    endfunction

    function automatic logic [SIZE-1:0] fill(input logic [7:0] b);
        return {NPIX{b}};
    endfunction

    function automatic logic [SIZE-1:0] ramp();
        logic [SIZE-1:0] w;
        for (int i = 0; i < NPIX; i++) w[i*8 +: 8] = 8'(2 * i);
        return w;
    endfunction

    // Behavioural units: a response is driven in the cycle that is 'delay' cycles after the start pulse.
    always @(negedge clk) begin
        ifa.mean_out_valid = 1'b0;
        if (ifa.mean_rst) am_busy = 1'b0;
        else if (ifa.mean_in_valid) begin am_cnt = 0; am_busy = 1'b1; end
        else if (am_busy) begin
            am_cnt++;
            if (am_cnt == a_m_dly) begin
                ifa.mean_out_valid = 1'b1;
                ifa.mean_value     = mean_of(ifa.mean_values);
                am_busy            = 1'b0;
            end
        end
        ifa.var_out_valid = 1'b0;
        if (ifa.var_rst) av_busy = 1'b0;
        else if (ifa.var_in_valid) begin av_cnt = 0; av_busy = 1'b1; end
        else if (av_busy) begin
            av_cnt++;
            if (av_cnt == a_v_dly) begin
                ifa.var_out_valid = 1'b1;
                ifa.var_value     = var_of(ifa.var_values, ifa.var_mean);
                av_busy           = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        ifb.mean_out_valid = 1'b0;
        if (ifb.mean_rst) bm_busy = 1'b0;
        else if (ifb.mean_in_valid) begin bm_cnt = 0; bm_busy = b_m_en; end
        else if (bm_busy) begin
            bm_cnt++;
            if (bm_cnt == b_m_dly) begin
                ifb.mean_out_valid = 1'b1;
                ifb.mean_value     = mean_of(ifb.mean_values);
                bm_busy            = 1'b0;
            end
        end
        ifb.var_out_valid = 1'b0;
        if (ifb.var_rst) bv_busy = 1'b0;
        else if (ifb.var_in_valid) begin bv_cnt = 0; bv_busy = b_v_en; end
        else if (bv_busy) begin
            bv_cnt++;
            if (bv_cnt == b_v_dly) begin
                ifb.var_out_valid = 1'b1;
                ifb.var_value     = var_of(ifb.var_values, ifb.var_mean);
                bv_busy           = 1'b0;
            end
        end
    end

    // Result monitors: pop the scoreboard on every handshake.
    always @(negedge clk) begin
        result_t e;
        if (rst_a && ifa.out_valid && ifa.out_ready) begin
            if (qa.size() == 0) check("a_unexpected_result", 1, 0);
            else begin
                e = qa.pop_front();
                check("a_mean", ifa.out_mean, e.mean);
                check("a_var", ifa.out_var, e.vr);
                check("a_err", ifa.out_error, e.err);
            end
        end
    end

    always @(negedge clk) begin
        result_t e;
        if (rst_b) begin
            if (ifb.mean_rst) clr_b = 1'b1;
            if (ifb.mean_in_valid) begin
                check("clear_before_start", clr_b, 1);
                clr_b = 1'b0;
            end
            if (ifb.var_in_valid) vpulse_b++;
            if (ifb.out_valid && ifb.out_ready) begin
                if (qb.size() == 0) check("b_unexpected_result", 1, 0);
                else begin
                    e = qb.pop_front();
                    check("b_mean", ifb.out_mean, e.mean);
                    check("b_var", ifb.out_var, e.vr);
                    check("b_err", ifb.out_error, e.err);
                end
            end
        end
    end

    task automatic send_b(input logic [SIZE-1:0] w, input result_t e, input bit hold);
        bit got;
        @(posedge clk); #1;
        ifb.in_values = w;
        ifb.in_valid  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = ifb.in_ready;
        end
        check("b_accept", got, 1);
        if (got) qb.push_back(e);
        if (!hold) begin
            @(posedge clk); #1;
            ifb.in_valid = 1'b0;
        end
    endtask

    task automatic wait_jc_b(input logic [15:0] target, input int max);
        for (int i = 0; i < max && jc_b !== target; i++) @(negedge clk);
        check("b_job_count", jc_b, target);
    endtask

    task automatic wait_out_b(input int max);
        for (int i = 0; i < max && ifb.out_valid !== 1'b1; i++) @(negedge clk);
        check("b_out_valid_wait", ifb.out_valid, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ov;
        logic [7:0] cm, cv;
        logic       ce;
        logic [15:0] jc0;

        ifa.in_values = '0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
        ifb.in_values = '0; ifb.in_valid = 1'b0; ifb.out_ready = 1'b1;
        ifa.mean_value = '0; ifa.var_value = '0;
        ifb.mean_value = '0; ifb.var_value = '0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);

        // Reset state, observed while reset is still asserted
        @(negedge clk);
        check("rst_in_ready", ifb.in_ready, 1);
        check("rst_busy", busy_b, 0);
        check("rst_out_valid", ifb.out_valid, 0);
        check("rst_out_vals", {ifb.out_mean, ifb.out_var, ifb.out_error}, 0);
        check("rst_job_count", jc_b, 0);
        check("rst_starts", {ifb.mean_in_valid, ifb.var_in_valid}, 0);
        check("rst_window", ifb.mean_values, 0);
        check("rst_var_mean", ifb.var_mean, 0);
        check("rst_unit_rst", {ifb.mean_rst, ifb.var_rst}, 2'b11);
        @(posedge clk); #1;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Uniform 0x64 window, both units answering after 70 cycles
        @(posedge clk); #1;
        ifa.in_values = fill(8'h64);
        ifa.in_valid  = 1'b1;
        qa.push_back('{mean: 8'h64, vr: 8'h00, err: 1'b0});
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        for (int i = 0; i < 400 && jc_a !== 16'd1; i++) @(negedge clk);
        check("a_job_count", jc_a, 1);
        check("a_queue_drained", qa.size(), 0);

        // Reset during VAR_WAIT abandons the job; in_valid in the reset cycle is ignored
        b_v_dly = 10;
        send_b(fill(8'h30), '{mean: 8'h30, vr: 8'h00, err: 1'b0}, 1'b0);
        for (int i = 0; i < 100 && ifb.var_in_valid !== 1'b1; i++) @(negedge clk);
        check("b_var_start_seen", ifb.var_in_valid, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_b = 1'b0;
        ifb.in_values = fill(8'h77);
        ifb.in_valid  = 1'b1;
        @(negedge clk);
        check("abort_unit_rst", {ifb.mean_rst, ifb.var_rst}, 2'b11);
        @(posedge clk); #1;
        rst_b = 1'b1;
        ifb.in_valid = 1'b0;
        @(negedge clk);
        check("abort_idle", {busy_b, ifb.in_ready}, 2'b01);
        check("abort_not_accepted", ifb.mean_values, 0);
        ov = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            ov += int'(ifb.out_valid);
        end
        check("abort_no_result", ov, 0);
        check("abort_job_count", jc_b, 0);
        qb.delete();
        b_v_dly = 4;

        // Output held for 10 cycles by out_ready=0
        ifb.out_ready = 1'b0;
        send_b(ramp(), '{mean: 8'd7, vr: 8'd21, err: 1'b0}, 1'b0);
        wait_out_b(100);
        cm = ifb.out_mean; cv = ifb.out_var; ce = ifb.out_error;
        for (int i = 0; i < 10; i++) begin
            check("hold_stable", {ifb.out_valid, ifb.in_ready, ifb.out_mean, ifb.out_var, ifb.out_error},
                  {1'b1, 1'b0, cm, cv, ce});
            if (i < 9) @(negedge clk);
        end
        @(posedge clk); #1;
        ifb.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_released_ready", ifb.in_ready, 1);
        check("hold_job_count", jc_b, 1);

        // Mean unit never answers: timeout 16 cycles after MEAN_START, no variance start
        b_m_en = 1'b0;
        vpulse_b = 0;
        send_b(fill(8'h55), '{mean: 8'h00, vr: 8'h00, err: 1'b1}, 1'b0);
        for (int i = 0; i < 50 && ifb.mean_in_valid !== 1'b1; i++) @(negedge clk);
        check("tmo_start_seen", ifb.mean_in_valid, 1);
        n = 0;
        while (n < 40 && ifb.out_valid !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        check("tmo_latency", n, 16);
        wait_jc_b(16'd2, 20);
        check("tmo_no_var_start", vpulse_b, 0);
        b_m_en = 1'b1;

        // Back-to-back windows with in_valid held high
        jc0 = jc_b;
        send_b(fill(8'h10), '{mean: 8'h10, vr: 8'h00, err: 1'b0}, 1'b1);
        send_b(fill(8'h20), '{mean: 8'h20, vr: 8'h00, err: 1'b0}, 1'b0);
        check("b2b_second_after_first", jc_b, jc0 + 16'd1);
        wait_jc_b(jc0 + 16'd2, 100);

        // Variance response on the timeout cycle wins
        b_v_dly = 15;
        send_b(ramp(), '{mean: 8'd7, vr: 8'd21, err: 1'b0}, 1'b0);
        wait_jc_b(16'd5, 100);

        // One cycle later it times out: mean kept, variance forced to 0
        b_v_dly = 16;
        send_b(ramp(), '{mean: 8'd7, vr: 8'd0, err: 1'b1}, 1'b0);
        wait_jc_b(16'd6, 100);
        check("b_queue_drained", qb.size(), 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
